// File: rtl/ux607_expl_axi_arb_pkg.sv
// Shared types for the two-master example-slave AXI arbiter:
// FSM encoding and request source indices.
package ux607_expl_axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_e;

    localparam int NSRC = 4;

    localparam logic [1:0] SRC_M0_RD = 2'd0;
    localparam logic [1:0] SRC_M0_WR = 2'd1;
    localparam logic [1:0] SRC_M1_RD = 2'd2;
    localparam logic [1:0] SRC_M1_WR = 2'd3;

endpackage

// File: rtl/ux607_expl_axi_arb_if.sv
// One AXI bundle (4-bit len, 2-bit lock); master drives AR/AW/W
// and the R/B readies, slave drives the rest.
interface ux607_expl_axi_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          arvalid;
    logic [AW-1:0] araddr;
    logic [3:0]    arcache;
    logic [2:0]    arprot;
    logic [1:0]    arlock;
    logic [1:0]    arburst;
    logic [3:0]    arlen;
    logic [2:0]    arsize;
    logic          arready;

    logic          awvalid;
    logic [AW-1:0] awaddr;
    logic [3:0]    awcache;
    logic [2:0]    awprot;
    logic [1:0]    awlock;
    logic [1:0]    awburst;
    logic [3:0]    awlen;
    logic [2:0]    awsize;
    logic          awready;

    logic            wvalid;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast;
    logic            wready;

    logic          rvalid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rready;

    logic       bvalid;
    logic [1:0] bresp;
    logic       bready;

    modport master (
        output arvalid, araddr, arcache, arprot,
        output arlock, arburst, arlen, arsize,
        input  arready,
        output awvalid, awaddr, awcache, awprot,
        output awlock, awburst, awlen, awsize,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  rvalid, rdata, rresp, rlast,
        output rready,
        input  bvalid, bresp,
        output bready
    );

    modport slave (
        input  arvalid, araddr, arcache, arprot,
        input  arlock, arburst, arlen, arsize,
        output arready,
        input  awvalid, awaddr, awcache, awprot,
        input  awlock, awburst, awlen, awsize,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output rvalid, rdata, rresp, rlast,
        input  rready,
        output bvalid, bresp,
        input  bready
    );

endinterface

// File: rtl/ux607_expl_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr,
// wrapping modulo the source count.
module ux607_expl_rr_pick
    import ux607_expl_axi_arb_pkg::*;
(
    input  logic [NSRC-1:0] req,
    input  logic [1:0]      ptr,
    output logic [1:0]      idx,
    output logic            found
);

    logic [1:0] cand;

    always_comb begin
        idx   = ptr;
        found = 1'b0;
        cand  = ptr;
        for (int k = 0; k < NSRC; k++) begin
            cand = ptr + 2'(k);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ux607_expl_axi_arb.sv
// Two-master AXI arbiter for the example slave: one transaction
// at a time, round-robin over m0 rd/wr and m1 rd/wr.
module ux607_expl_axi_arb
    import ux607_expl_axi_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ux607_expl_axi_arb_if.slave   m0,
    ux607_expl_axi_arb_if.slave   m1,
    ux607_expl_axi_arb_if.master  s,
    output logic                  arb_busy,
    output logic [1:0]            arb_gnt
);

    state_e     state_q, state_d;
    logic [1:0] ptr_q, gnt_q, gnt_d, pick;
    logic       found;
    logic       ar_done_q, aw_done_q, w_done_q;
    logic [NSRC-1:0] req;

    assign req = {m1.awvalid, m1.arvalid, m0.awvalid, m0.arvalid};

    ux607_expl_rr_pick u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .idx   (pick),
        .found (found)
    );

    logic rd, wr, sel1, ar_fwd, aw_fwd, w_fwd;
    logic rd0, rd1, wr0, wr1;

    assign rd     = (state_q == RD);
    assign wr     = (state_q == WR);
    assign sel1   = gnt_q[1];
    assign rd0    = rd & ~sel1;
    assign rd1    = rd & sel1;
    assign wr0    = wr & ~sel1;
    assign wr1    = wr & sel1;
    // Address and data phases close once done so a master's next
    // request is not forwarded into the transaction still in flight.
    assign ar_fwd = rd & ~ar_done_q;
    assign aw_fwd = wr & ~aw_done_q;
    assign w_fwd  = wr & ~w_done_q;

    // Slave-facing requests
    assign s.arvalid = ar_fwd & (sel1 ? m1.arvalid : m0.arvalid);
    assign s.araddr  = !ar_fwd ? {AW{1'b0}} :
                       sel1 ? m1.araddr : m0.araddr;
    assign {s.arcache, s.arprot, s.arlock,
            s.arburst, s.arlen, s.arsize} =
        !ar_fwd ? '0 :
        sel1 ? {m1.arcache, m1.arprot, m1.arlock,
                m1.arburst, m1.arlen, m1.arsize}
             : {m0.arcache, m0.arprot, m0.arlock,
                m0.arburst, m0.arlen, m0.arsize};

    assign s.awvalid = aw_fwd & (sel1 ? m1.awvalid : m0.awvalid);
    assign s.awaddr  = !aw_fwd ? {AW{1'b0}} :
                       sel1 ? m1.awaddr : m0.awaddr;
    assign {s.awcache, s.awprot, s.awlock,
            s.awburst, s.awlen, s.awsize} =
        !aw_fwd ? '0 :
        sel1 ? {m1.awcache, m1.awprot, m1.awlock,
                m1.awburst, m1.awlen, m1.awsize}
             : {m0.awcache, m0.awprot, m0.awlock,
                m0.awburst, m0.awlen, m0.awsize};

    assign s.wvalid = w_fwd & (sel1 ? m1.wvalid : m0.wvalid);
    assign s.wdata  = !w_fwd ? {DW{1'b0}} :
                      sel1 ? m1.wdata : m0.wdata;
    assign {s.wstrb, s.wlast} =
        !w_fwd ? '0 :
        sel1 ? {m1.wstrb, m1.wlast} : {m0.wstrb, m0.wlast};

    assign s.rready = rd & (sel1 ? m1.rready : m0.rready);
    assign s.bready = wr & (sel1 ? m1.bready : m0.bready);

    // Master-facing responses
    assign m0.arready = ar_fwd & ~sel1 & s.arready;
    assign m1.arready = ar_fwd & sel1 & s.arready;
    assign m0.awready = aw_fwd & ~sel1 & s.awready;
    assign m1.awready = aw_fwd & sel1 & s.awready;
    assign m0.wready  = w_fwd & ~sel1 & s.wready;
    assign m1.wready  = w_fwd & sel1 & s.wready;

    assign m0.rvalid = rd0 & s.rvalid;
    assign m1.rvalid = rd1 & s.rvalid;
    assign m0.rdata  = rd0 ? s.rdata : {DW{1'b0}};
    assign m1.rdata  = rd1 ? s.rdata : {DW{1'b0}};
    assign {m0.rresp, m0.rlast} = rd0 ? {s.rresp, s.rlast} : '0;
    assign {m1.rresp, m1.rlast} = rd1 ? {s.rresp, s.rlast} : '0;

    assign m0.bvalid = wr0 & s.bvalid;
    assign m1.bvalid = wr1 & s.bvalid;
    assign m0.bresp  = wr0 ? s.bresp : 2'b00;
    assign m1.bresp  = wr1 ? s.bresp : 2'b00;

    logic ar_hs, r_end, aw_hs, w_end, b_hs;
    logic rd_exit, wr_exit, done;

    assign ar_hs = s.arvalid & s.arready;
    assign r_end = s.rvalid & s.rready & s.rlast;
    assign aw_hs = s.awvalid & s.awready;
    assign w_end = s.wvalid & s.wready & s.wlast;
    assign b_hs  = s.bvalid & s.bready;

    assign rd_exit = rd & r_end & (ar_done_q | ar_hs);
    assign wr_exit = wr & b_hs & (aw_done_q | aw_hs)
                   & (w_done_q | w_end);
    assign done    = rd_exit | wr_exit;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        unique case (state_q)
            IDLE: if (found) begin
                gnt_d   = pick;
                state_d = pick[0] ? WR : RD;
            end
            RD:      if (rd_exit) state_d = IDLE;
            WR:      if (wr_exit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            gnt_q     <= 2'd0;
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            if (done) begin
                ptr_q     <= gnt_q + 2'd1;
                ar_done_q <= 1'b0;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end else begin
                if (ar_hs) ar_done_q <= 1'b1;
                if (aw_hs) aw_done_q <= 1'b1;
                if (w_end) w_done_q  <= 1'b1;
            end
        end
    end

    assign arb_busy = (state_q != IDLE);
    assign arb_gnt  = gnt_q;

endmodule

// File: tb/tb_ux607_expl_axi_arb.sv
// Directed bench for the example-slave AXI arbiter: grant order,
// forwarding, exit conditions, back-pressure and reset.
module tb_ux607_expl_axi_arb;
    import ux607_expl_axi_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ux607_expl_axi_arb_if #(.AW(32), .DW(32)) m0_if ();
    ux607_expl_axi_arb_if #(.AW(32), .DW(32)) m1_if ();
    ux607_expl_axi_arb_if #(.AW(32), .DW(32)) s_if ();

    logic       arb_busy;
    logic [1:0] arb_gnt;

    ux607_expl_axi_arb #(.AW(32), .DW(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0       (m0_if),
        .m1       (m1_if),
        .s        (s_if),
        .arb_busy (arb_busy),
        .arb_gnt  (arb_gnt)
    );

    // Slave model; comb mode answers R with AR and B with last W.
    logic        sl_comb, sl_arready, sl_awready, sl_wready;
    logic        sl_rvalid, sl_rlast, sl_bvalid;
    logic [31:0] sl_rdata;
    logic [1:0]  sl_rresp, sl_bresp;

    assign s_if.arready = sl_arready;
    assign s_if.awready = sl_awready;
    assign s_if.wready  = sl_wready;
    assign s_if.rvalid  = sl_comb ? s_if.arvalid : sl_rvalid;
    assign s_if.rdata   = sl_rdata;
    assign s_if.rresp   = sl_rresp;
    assign s_if.rlast   = sl_rlast;
    assign s_if.bvalid  = sl_comb ? (s_if.wvalid & s_if.wlast)
                                  : sl_bvalid;
    assign s_if.bresp   = sl_bresp;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h",
                      tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clr_masters();
        {m0_if.arvalid, m0_if.araddr, m0_if.arcache, m0_if.arprot,
         m0_if.arlock, m0_if.arburst, m0_if.arlen, m0_if.arsize} = '0;
        {m0_if.awvalid, m0_if.awaddr, m0_if.awcache, m0_if.awprot,
         m0_if.awlock, m0_if.awburst, m0_if.awlen, m0_if.awsize} = '0;
        {m0_if.wvalid, m0_if.wdata, m0_if.wstrb, m0_if.wlast} = '0;
        {m0_if.rready, m0_if.bready} = '0;
        {m1_if.arvalid, m1_if.araddr, m1_if.arcache, m1_if.arprot,
         m1_if.arlock, m1_if.arburst, m1_if.arlen, m1_if.arsize} = '0;
        {m1_if.awvalid, m1_if.awaddr, m1_if.awcache, m1_if.awprot,
         m1_if.awlock, m1_if.awburst, m1_if.awlen, m1_if.awsize} = '0;
        {m1_if.wvalid, m1_if.wdata, m1_if.wstrb, m1_if.wlast} = '0;
        {m1_if.rready, m1_if.bready} = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    logic [2:0] seq [9];

    initial begin
        seq = '{3'b100, 3'b000, 3'b101, 3'b001, 3'b110,
                3'b010, 3'b111, 3'b011, 3'b100};
        rst_n = 1'b0;
        clr_masters();
        m0_if.rready = 1'b1;
        m0_if.bready = 1'b1;
        sl_comb = 1'b0; sl_arready = 1'b1; sl_awready = 1'b1;
        sl_wready = 1'b1; sl_rvalid = 1'b1; sl_rlast = 1'b1;
        sl_bvalid = 1'b1; sl_rdata = 32'hDEAD_BEEF;
        sl_rresp = 2'b01; sl_bresp = 2'b11;
        tick();
        tick();
        settle();

        // reset state
        check("rst_busy_gnt", {arb_busy, arb_gnt}, 3'b000);
        check("rst_s_valids", {s_if.arvalid, s_if.awvalid,
              s_if.wvalid, s_if.rready, s_if.bready}, 5'b0);
        check("rst_m0_out", {m0_if.arready, m0_if.awready,
              m0_if.wready, m0_if.rvalid, m0_if.bvalid}, 5'b0);
        check("rst_m0_rdata", {m0_if.rdata, m0_if.rresp,
              m0_if.rlast, m0_if.bresp}, 37'b0);

        // single m0 read, zero-latency slave
        rst_n = 1'b1;
        sl_rvalid = 1'b0; sl_bvalid = 1'b0; sl_comb = 1'b1;
        sl_rdata = 32'hA5A5_0001; sl_rresp = 2'b00;
        m0_if.arvalid = 1'b1; m0_if.araddr = 32'h100;
        m0_if.arcache = 4'h3; m0_if.arprot = 3'h2;
        m0_if.arburst = 2'h1; m0_if.arsize = 3'h2;
        m1_if.rready = 1'b1;
        settle();
        check("t1_idle_arvalid", s_if.arvalid, 1'b0);
        tick();
        settle();
        check("t1_rd_busy_gnt", {arb_busy, arb_gnt}, 3'b100);
        check("t1_s_araddr", s_if.araddr, 32'h100);
        check("t1_s_arattr", {s_if.arcache, s_if.arprot, s_if.arlock,
              s_if.arburst, s_if.arlen, s_if.arsize},
              {4'h3, 3'h2, 2'h0, 2'h1, 4'h0, 3'h2});
        check("t1_m0_ar_r", {s_if.arvalid, m0_if.arready,
              m0_if.rvalid, m0_if.rlast}, 4'b1111);
        check("t1_m0_rdata", m0_if.rdata, 32'hA5A5_0001);
        check("t1_m1_quiet", {m1_if.arready, m1_if.rvalid}, 2'b00);
        tick();
        m0_if.arvalid = 1'b0;
        settle();
        check("t1_exit", {arb_busy, arb_gnt, m0_if.rvalid}, 4'b0000);

        // m1 write with combinational B and error resp
        m1_if.awvalid = 1'b1; m1_if.awaddr = 32'h200;
        m1_if.awcache = 4'h2; m1_if.awprot = 3'h1;
        m1_if.awlock = 2'h1; m1_if.awburst = 2'h1;
        m1_if.awsize = 3'h2;
        m1_if.wvalid = 1'b1; m1_if.wdata = 32'hCAFE_0002;
        m1_if.wstrb = 4'hF; m1_if.wlast = 1'b1;
        m1_if.bready = 1'b1;
        m0_if.wvalid = 1'b1; m0_if.wdata = 32'h0BAD_0BAD;
        m0_if.wlast = 1'b1;
        sl_bresp = 2'b10;
        settle();
        check("t2_idle_w", {s_if.wvalid, m1_if.wready}, 2'b00);
        tick();
        settle();
        check("t2_wr_busy_gnt", {arb_busy, arb_gnt}, 3'b111);
        check("t2_s_aw", {s_if.awvalid, s_if.awaddr}, {1'b1, 32'h200});
        check("t2_s_awattr", {s_if.awcache, s_if.awprot, s_if.awlock,
              s_if.awburst, s_if.awlen, s_if.awsize},
              {4'h2, 3'h1, 2'h1, 2'h1, 4'h0, 3'h2});
        check("t2_s_w", {s_if.wdata, s_if.wstrb, s_if.wlast},
              {32'hCAFE_0002, 4'hF, 1'b1});
        check("t2_m1_hs", {m1_if.awready, m1_if.wready,
              m1_if.bvalid, m1_if.bresp}, 5'b11110);
        check("t2_m0_blocked", {m0_if.wready, m0_if.bvalid}, 2'b00);
        tick();
        m1_if.awvalid = 1'b0; m1_if.wvalid = 1'b0;
        m0_if.wvalid = 1'b0;
        m0_if.arvalid = 1'b1; m1_if.arvalid = 1'b1;
        settle();
        check("t2_exit", {arb_busy, arb_gnt}, 3'b011);
        tick();
        settle();
        check("t2_ptr_wrap", {arb_busy, arb_gnt}, 3'b100);
        tick();
        m0_if.arvalid = 1'b0;
        settle();
        check("t2_bubble", arb_busy, 1'b0);
        tick();
        settle();
        check("t2_m1_rd", {arb_busy, arb_gnt, m1_if.rvalid,
              m0_if.rvalid}, 5'b11010);
        check("t2_m1_rdata", m1_if.rdata, 32'hA5A5_0001);
        tick();
        m1_if.arvalid = 1'b0;
        settle();
        check("t2_m1_exit", arb_busy, 1'b0);

        // contention: all four sources from reset
        rst_n = 1'b0;
        m0_if.arvalid = 1'b1; m0_if.awvalid = 1'b1;
        m0_if.wvalid = 1'b1; m0_if.wlast = 1'b1;
        m1_if.arvalid = 1'b1; m1_if.awvalid = 1'b1;
        m1_if.wvalid = 1'b1; m1_if.wlast = 1'b1;
        sl_arready = 1'b1; sl_awready = 1'b1; sl_wready = 1'b1;
        sl_rlast = 1'b1; sl_comb = 1'b1; sl_bresp = 2'b00;
        tick();
        rst_n = 1'b1;
        settle();
        check("t3_start", {arb_busy, arb_gnt}, 3'b000);
        for (int i = 0; i < 9; i++) begin
            tick();
            settle();
            check($sformatf("t3_seq%0d", i), {arb_busy, arb_gnt},
                  seq[i]);
        end

        // m0 4-beat write, AW accepted late, B held high early
        rst_n = 1'b0;
        clr_masters();
        tick();
        rst_n = 1'b1;
        sl_comb = 1'b0; sl_awready = 1'b0; sl_wready = 1'b1;
        sl_bvalid = 1'b1;
        m0_if.awvalid = 1'b1; m0_if.awaddr = 32'h300;
        m0_if.awlen = 4'd3;
        m0_if.wvalid = 1'b1; m0_if.wdata = 32'h1000;
        m0_if.wlast = 1'b0; m0_if.bready = 1'b1;
        m1_if.wvalid = 1'b1; m1_if.wdata = 32'hBAD;
        m1_if.wlast = 1'b1;
        settle();
        check("t4_idle_wready", m0_if.wready, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            m0_if.wdata   = 32'h1000 + 32'(c - 1);
            m0_if.wlast   = (c == 4);
            m0_if.awvalid = (c <= 3);
            sl_awready    = (c == 3);
            settle();
            check($sformatf("t4_busy%0d", c), {arb_busy, arb_gnt},
                  3'b101);
            check($sformatf("t4_wready%0d", c),
                  {m0_if.wready, m1_if.wready}, 2'b10);
            check($sformatf("t4_wdata%0d", c), s_if.wdata,
                  32'h1000 + 32'(c - 1));
            check($sformatf("t4_awready%0d", c), m0_if.awready,
                  (c == 3));
            check($sformatf("t4_bvalid%0d", c), m0_if.bvalid, 1'b1);
        end
        tick();
        m0_if.wvalid = 1'b0; m1_if.wvalid = 1'b0;
        settle();
        check("t4_exit", {arb_busy, s_if.wvalid}, 2'b00);

        // m1 read with rready back-pressure
        sl_bvalid = 1'b0; sl_arready = 1'b1;
        m1_if.arvalid = 1'b1; m1_if.araddr = 32'h400;
        m1_if.rready = 1'b0;
        settle();
        check("t5_idle_ar", s_if.arvalid, 1'b0);
        tick();
        sl_rvalid = 1'b1; sl_rdata = 32'hBEEF_0005;
        sl_rlast = 1'b1; sl_rresp = 2'b10;
        settle();
        check("t5_ar", {arb_busy, arb_gnt, s_if.arvalid,
              m1_if.arready}, 5'b11011);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) begin
                tick();
                m1_if.arvalid = 1'b0;
                settle();
            end
            check($sformatf("t5_hold%0d", c), {arb_busy,
                  s_if.rready, m1_if.rvalid}, 3'b101);
            check($sformatf("t5_rdata%0d", c), m1_if.rdata,
                  32'hBEEF_0005);
        end
        tick();
        m1_if.rready = 1'b1;
        settle();
        check("t5_release", {s_if.rready, m1_if.rresp}, 3'b110);
        tick();
        settle();
        check("t5_exit", arb_busy, 1'b0);

        // reset mid-read, then m0 before pending m1 read
        sl_rvalid = 1'b0; sl_arready = 1'b0; sl_rresp = 2'b00;
        m1_if.arvalid = 1'b1; m1_if.araddr = 32'h500;
        m0_if.rready = 1'b1;
        tick();
        settle();
        check("t6_pre_rst", {arb_busy, arb_gnt, s_if.araddr},
              {3'b110, 32'h500});
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sl_comb = 1'b1; sl_arready = 1'b1; sl_rlast = 1'b1;
        sl_rdata = 32'h6666_0006;
        m0_if.arvalid = 1'b1; m0_if.araddr = 32'h600;
        m1_if.awvalid = 1'b1;
        settle();
        check("t6_rst_state", {arb_busy, arb_gnt}, 3'b000);
        check("t6_rst_out", {s_if.arvalid, s_if.rready,
              m1_if.arready, m1_if.rvalid, m0_if.rvalid}, 5'b0);
        check("t6_rst_rdata", {m0_if.rdata, m1_if.rdata}, 64'b0);
        tick();
        settle();
        check("t6_m0_first", {arb_busy, arb_gnt}, 3'b100);
        check("t6_m0_rdata", m0_if.rdata, 32'h6666_0006);
        tick();
        m0_if.arvalid = 1'b0;
        settle();
        check("t6_bubble", arb_busy, 1'b0);
        tick();
        settle();
        check("t6_m1_next", {arb_busy, arb_gnt, m1_if.rvalid},
              4'b1101);
        tick();
        m1_if.arvalid = 1'b0; m1_if.awvalid = 1'b0;
        settle();
        check("t6_done", arb_busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
